// File: rtl/ks_pkg.sv
// ks_pkg: definitions shared by the Kogge-Stone adder family.
//   ks_clog2      - constant ceil(log2(v)), usable in parameter expressions
//   ks_stages     - number of prefix levels for a given operand width
//   ks_gp_t       - one (generate, propagate) pair
//   ks_prefix_op  - the associative prefix operator; shared with any
//                   Brent-Kung / Sklansky variant built on the same cells
package ks_pkg;

  localparam int unsigned KS_DEFAULT_WIDTH = 16;

  typedef struct packed {
    logic g;
    logic p;
  } ks_gp_t;

  function automatic int unsigned ks_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ks_stages(input int unsigned width);
    return ks_clog2(width);
  endfunction

  // hi is the more significant group, lo the adjacent lower group.
  function automatic ks_gp_t ks_prefix_op(input ks_gp_t hi, input ks_gp_t lo);
    ks_gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ks_black_cell.sv
// ks_black_cell: combinational prefix ("black") cell.
//   g_hi, p_hi : group generate/propagate of the upper span
//   g_lo, p_lo : group generate/propagate of the adjacent lower span
//   g_out      : g_hi | (p_hi & g_lo)
//   p_out      : p_hi & p_lo
module ks_black_cell
  import ks_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  ks_gp_t hi;
  ks_gp_t lo;
  ks_gp_t res;

  always_comb begin
    hi    = '{g: g_hi, p: p_hi};
    lo    = '{g: g_lo, p: p_lo};
    res   = ks_prefix_op(hi, lo);
    g_out = res.g;
    p_out = res.p;
  end

endmodule

// File: rtl/ks_prefix_post.sv
// ks_prefix_post: pipelined Kogge-Stone back end. Takes per-bit p/g vectors
// and a carry-in, runs the log2(WIDTH)-level prefix tree with one register
// per level, then registers sum and carry-out. Latency STAGES+1 cycles.
// Flow control is a global stall: every slot loads only when the output
// slot is empty or being consumed.
//   clk, rst_n            : clock, asynchronous active-low reset
//   p_in, g_in, cin       : propagate, generate, carry into bit 0
//   in_valid / in_ready   : input handshake (in_ready = advance)
//   sum, cout             : result, carry out of bit WIDTH-1
//   out_valid / out_ready : output handshake
module ks_prefix_post
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned STAGES = ks_stages(WIDTH);

  logic advance;

  // Entry vectors with the carry-in folded into bit 0.
  logic [WIDTH-1:0] g_ent;
  logic [WIDTH-1:0] p_ent;

  // Combinational output of each prefix level.
  logic [STAGES-1:0][WIDTH-1:0] g_lvl;
  logic [STAGES-1:0][WIDTH-1:0] p_lvl;

  // Per-level slot registers.
  logic [STAGES-1:0][WIDTH-1:0] g_q, g_d;
  logic [STAGES-1:0][WIDTH-1:0] p_q, p_d;
  logic [STAGES-1:0][WIDTH-1:0] praw_q, praw_d;  // original p_in delay line
  logic [STAGES-1:0]            cin_q, cin_d;    // original cin delay line
  logic [STAGES-1:0]            vld_q, vld_d;

  // Sum-stage slot.
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovld_q, ovld_d;

  always_comb begin
    g_ent    = g_in;
    p_ent    = p_in;
    g_ent[0] = g_in[0] | (p_in[0] & cin);
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_level
    localparam int D = 1 << k;
    logic [WIDTH-1:0] g_src;
    logic [WIDTH-1:0] p_src;

    if (k == 0) begin : g_src_entry
      assign g_src = g_ent;
      assign p_src = p_ent;
    end else begin : g_src_prev
      assign g_src = g_q[k-1];
      assign p_src = p_q[k-1];
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      if (i >= D) begin : g_cell
        ks_black_cell u_cell (
          .g_hi  (g_src[i]),
          .p_hi  (p_src[i]),
          .g_lo  (g_src[i-D]),
          .p_lo  (p_src[i-D]),
          .g_out (g_lvl[k][i]),
          .p_out (p_lvl[k][i])
        );
      end else begin : g_pass
        assign g_lvl[k][i] = g_src[i];
        assign p_lvl[k][i] = p_src[i];
      end
    end
  end

  always_comb begin
    advance = !ovld_q | out_ready;

    g_d    = g_q;
    p_d    = p_q;
    praw_d = praw_q;
    cin_d  = cin_q;
    vld_d  = vld_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovld_d = ovld_q;

    if (advance) begin
      g_d = g_lvl;
      p_d = p_lvl;

      praw_d[0] = p_in;
      cin_d[0]  = cin;
      vld_d[0]  = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        praw_d[k] = praw_q[k-1];
        cin_d[k]  = cin_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end

      // Carry into bit i is the final group generate of bits [i-1:0];
      // bit 0 takes the raw carry-in.
      sum_d  = praw_q[STAGES-1] ^ {g_q[STAGES-1][WIDTH-2:0], cin_q[STAGES-1]};
      cout_d = g_q[STAGES-1][WIDTH-1];
      ovld_d = vld_q[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q    <= '0;
      p_q    <= '0;
      praw_q <= '0;
      cin_q  <= '0;
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovld_q <= 1'b0;
    end else begin
      g_q    <= g_d;
      p_q    <= p_d;
      praw_q <= praw_d;
      cin_q  <= cin_d;
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovld_q <= ovld_d;
    end
  end

  assign in_ready  = advance;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = ovld_q;

endmodule
